req_ack_monitor: RTL

REQ_ACK_MONITOR -- requirements
Module: req_ack_monitor

---
 rtl/req_ack_pkg.sv | 23 ++
 rtl/req_ack_ch.sv | 77 +++++++
 rtl/req_ack_monitor.sv | 91 +++++++++
 3 files changed

// File: rtl/req_ack_pkg.sv
// Shared types and defaults for the req/ack latency monitor.
// popcount16 is sized for the largest supported channel count.
package req_ack_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } ch_state_t;

    localparam int DEF_NUM_CH  = 4;
    localparam int DEF_MAX_LAT = 4;
    localparam int DEF_CNT_W   = 16;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] cnt;
        cnt = '0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + 5'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/req_ack_ch.sv
// One req/ack channel: IDLE/WAIT FSM with a latency timer.
// Event outputs are combinational and qualify the current edge only.
module req_ack_ch
    import req_ack_pkg::*;
#(
    parameter int MAX_LAT = DEF_MAX_LAT
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_req,
    input  logic      i_ack,
    output ch_state_t o_state,
    output logic      o_pass,
    output logic      o_fail,
    output logic      o_spurious
);

    // A zero-latency limit still needs a 1-bit timer to keep the vector legal.
    localparam int TMR_W = (MAX_LAT < 1) ? 1 : $clog2(MAX_LAT + 1);
    localparam logic [TMR_W-1:0] LAT_LIMIT = TMR_W'(MAX_LAT);

    ch_state_t        r_state;
    ch_state_t        w_state_nxt;
    logic [TMR_W-1:0] r_timer;
    logic [TMR_W-1:0] w_timer_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        o_pass      = 1'b0;
        o_fail      = 1'b0;
        o_spurious  = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_req && i_ack) begin
                    o_pass = 1'b1;
                end else if (i_req) begin
                    if (MAX_LAT == 0) begin
                        o_fail = 1'b1;
                    end else begin
                        w_state_nxt = WAIT;
                        w_timer_nxt = TMR_W'(1);
                    end
                end else if (i_ack) begin
                    o_spurious = 1'b1;
                end
            end
            WAIT: begin
                // Ack wins over timeout on the same edge; req is ignored here.
                if (i_ack) begin
                    o_pass      = 1'b1;
                    w_state_nxt = IDLE;
                    w_timer_nxt = '0;
                end else if (r_timer == LAT_LIMIT) begin
                    o_fail      = 1'b1;
                    w_state_nxt = IDLE;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + TMR_W'(1);
                end
            end
        endcase
    end

    assign o_state = r_state;

endmodule

// File: rtl/req_ack_monitor.sv
// Multi-channel req/ack latency monitor: per-channel FSMs plus registered
// event pulses, sticky error flags and saturating pass/fail totals.
module req_ack_monitor
    import req_ack_pkg::*;
#(
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int MAX_LAT = DEF_MAX_LAT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic [NUM_CH-1:0] ack,
    input  logic              clr,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] pass_pulse,
    output logic [NUM_CH-1:0] fail_pulse,
    output logic [NUM_CH-1:0] err_sticky,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ch_state_t         w_state [NUM_CH];
    logic [NUM_CH-1:0] w_pass;
    logic [NUM_CH-1:0] w_fail;
    logic [NUM_CH-1:0] w_spur;
    logic [4:0]        w_pass_pop;
    logic [4:0]        w_fail_pop;
    logic [CNT_W-1:0]  w_pass_base;
    logic [CNT_W-1:0]  w_fail_base;

    logic [NUM_CH-1:0] r_pass_pulse;
    logic [NUM_CH-1:0] r_fail_pulse;
    logic [NUM_CH-1:0] r_err_sticky;
    logic [CNT_W-1:0]  r_pass_cnt;
    logic [CNT_W-1:0]  r_fail_cnt;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        req_ack_ch #(
            .MAX_LAT(MAX_LAT)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_req     (req[g]),
            .i_ack     (ack[g]),
            .o_state   (w_state[g]),
            .o_pass    (w_pass[g]),
            .o_fail    (w_fail[g]),
            .o_spurious(w_spur[g])
        );
        assign busy[g] = (w_state[g] == WAIT);
    end

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] base,
                                                 input logic [4:0] inc);
        logic [CNT_W+4:0] sum;
        sum = {5'b0, base} + {{CNT_W{1'b0}}, inc};
        return (sum > {5'b0, CNT_MAX}) ? CNT_MAX : sum[CNT_W-1:0];
    endfunction

    assign w_pass_pop  = popcount16(16'(w_pass));
    assign w_fail_pop  = popcount16(16'(w_fail));
    // Clear restarts totals from this edge's events rather than from zero.
    assign w_pass_base = clr ? '0 : r_pass_cnt;
    assign w_fail_base = clr ? '0 : r_fail_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pass_pulse <= '0;
            r_fail_pulse <= '0;
            r_err_sticky <= '0;
            r_pass_cnt   <= '0;
            r_fail_cnt   <= '0;
        end else begin
            r_pass_pulse <= w_pass;
            r_fail_pulse <= w_fail;
            r_err_sticky <= (clr ? '0 : r_err_sticky) | w_fail | w_spur;
            r_pass_cnt   <= sat_add(w_pass_base, w_pass_pop);
            r_fail_cnt   <= sat_add(w_fail_base, w_fail_pop);
        end
    end

    assign pass_pulse = r_pass_pulse;
    assign fail_pulse = r_fail_pulse;
    assign err_sticky = r_err_sticky;
    assign pass_cnt   = r_pass_cnt;
    assign fail_cnt   = r_fail_cnt;

endmodule
